// File: rtl/decode_skid_ctrl.sv
// Decode-stage flow controller: two-entry main/skid buffer between fetch and
// decode/execute, with load-use bubble insertion, flush and a bubble counter.
module decode_skid_ctrl #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               hazard_stall,
  input  logic               flush,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [PC_W-1:0]    main_pc_r;
  logic [INSTR_W-1:0] main_instr_r;
  logic [PC_W-1:0]    skid_pc_r;
  logic [INSTR_W-1:0] skid_instr_r;
  logic [CNT_W-1:0]   bubble_cnt_r;

  logic main_valid_s;
  logic in_fire_s;
  logic out_fire_s;
  logic load_main_in_s;
  logic load_main_skid_s;
  logic load_skid_s;
  logic bubble_s;

  assign main_valid_s = (state_r != EMPTY);
  assign in_ready     = (state_r != FULL) & ~flush & ~reset;
  assign out_valid    = main_valid_s & ~hazard_stall;
  assign in_fire_s    = in_valid & in_ready;
  assign out_fire_s   = out_valid & out_ready;
  assign bubble_s     = main_valid_s & hazard_stall & ~flush;

  assign out_pc     = main_pc_r;
  assign out_instr  = main_instr_r;
  assign bubble_cnt = bubble_cnt_r;

  // Next-state and payload-load decode; flush overrides every transition.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s    = ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_nxt_s    = ONE;
            load_main_in_s = 1'b1;
          end else if (in_fire_s) begin
            state_nxt_s = FULL;
            load_skid_s = 1'b1;
          end else if (out_fire_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            state_nxt_s      = ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty buffer.
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Main entry payload: filled from fetch or promoted from the skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_pc_r    <= '0;
      main_instr_r <= '0;
    end else if (load_main_in_s) begin
      main_pc_r    <= in_pc;
      main_instr_r <= in_instr;
    end else if (load_main_skid_s) begin
      main_pc_r    <= skid_pc_r;
      main_instr_r <= skid_instr_r;
    end
  end

  // Skid entry payload: catches the instruction accepted while main is stuck.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_pc_r    <= '0;
      skid_instr_r <= '0;
    end else if (load_skid_s) begin
      skid_pc_r    <= in_pc;
      skid_instr_r <= in_instr;
    end
  end

  // Saturating count of cycles where a held instruction was turned into a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_r <= '0;
    end else if (bubble_s && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_decode_skid_ctrl.sv
// Bench for decode_skid_ctrl: a queue-based occupancy model checked every
// cycle, directed scenarios with literal expectations, and random traffic.
module tb_decode_skid_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        hazard_stall;
  logic        flush;
  logic [15:0] bubble_cnt;

  int tests = 0;
  int errs  = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t m_q[$];
  int   m_cnt = 0;

  decode_skid_ctrl #(.PC_W(64), .INSTR_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .hazard_stall(hazard_stall), .flush(flush), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_0013;
  endfunction

  // Reference model: the buffer is a FIFO of at most two instructions.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      automatic bit m_in_fire  = in_valid && (m_q.size() < 2) && !flush;
      automatic bit m_out_fire = (m_q.size() > 0) && !hazard_stall && out_ready;
      if ((m_q.size() > 0) && hazard_stall && !flush && (m_cnt < 65535))
        m_cnt = m_cnt + 1;
      if (flush) begin
        m_q.delete();
      end else begin
        if (m_out_fire) void'(m_q.pop_front());
        if (m_in_fire) begin
          automatic ent_t e;
          e.pc    = in_pc;
          e.instr = in_instr;
          m_q.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("in_ready", in_ready, (m_q.size() < 2) && !flush && !reset);
    check("out_valid", out_valid, (m_q.size() > 0) && !hazard_stall);
    check("bubble_cnt", bubble_cnt, m_cnt);
    if (reset) begin
      check("rst_out_pc", out_pc, 64'h0);
      check("rst_out_instr", out_instr, 64'h0);
    end else if (m_q.size() > 0) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_instr", out_instr, m_q[0].instr);
    end
  end

  // One cycle: drive inputs after the edge, return mid-cycle before the next edge.
  task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                     input logic ordy, input logic hz, input logic fl);
    @(posedge clk);
    #1;
    in_valid     = v;
    in_pc        = pc;
    in_instr     = instr;
    out_ready    = ordy;
    hazard_stall = hz;
    flush        = fl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_pc = 64'h0; in_instr = 32'h0;
    out_ready = 1'b0; hazard_stall = 1'b0; flush = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 64'h0);
    check("rst_out_valid", out_valid, 64'h0);
    check("rst_bubble_cnt", bubble_cnt, 64'h0);
    #21;
    reset = 1'b0;

    // Streaming with no backpressure.
    cyc(1'b1, 64'h8000_0000, ins(64'h8000_0000), 1'b1, 1'b0, 1'b0);
    check("st_first_ready", in_ready, 64'h1);
    check("st_no_passthru", out_valid, 64'h0);
    cyc(1'b1, 64'h8000_0004, ins(64'h8000_0004), 1'b1, 1'b0, 1'b0);
    check("st_pc0", out_pc, 64'h8000_0000);
    check("st_instr0", out_instr, {32'h0, ins(64'h8000_0000)});
    cyc(1'b1, 64'h8000_0008, ins(64'h8000_0008), 1'b1, 1'b0, 1'b0);
    check("st_pc1", out_pc, 64'h8000_0004);
    check("st_ready1", in_ready, 64'h1);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("st_pc2", out_pc, 64'h8000_0008);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("st_drained", out_valid, 64'h0);

    // Backpressure fills main and skid.
    cyc(1'b1, 64'h8000_0000, ins(64'h8000_0000), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h8000_0004, ins(64'h8000_0004), 1'b0, 1'b0, 1'b0);
    check("bp_second_ready", in_ready, 64'h1);
    cyc(1'b1, 64'h8000_0008, ins(64'h8000_0008), 1'b0, 1'b0, 1'b0);
    check("bp_full_ready", in_ready, 64'h0);
    check("bp_hold_pc", out_pc, 64'h8000_0000);
    cyc(1'b1, 64'h8000_0008, ins(64'h8000_0008), 1'b1, 1'b0, 1'b0);
    check("bp_drain_pc0", out_pc, 64'h8000_0000);
    check("bp_drain_ready0", in_ready, 64'h0);
    cyc(1'b1, 64'h8000_0008, ins(64'h8000_0008), 1'b1, 1'b0, 1'b0);
    check("bp_drain_pc1", out_pc, 64'h8000_0004);
    check("bp_third_ready", in_ready, 64'h1);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("bp_drain_pc2", out_pc, 64'h8000_0008);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Load-use stall for three cycles.
    cyc(1'b1, 64'h8000_0010, ins(64'h8000_0010), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("lu_bubble_valid", out_valid, 64'h0);
      check("lu_hold_pc", out_pc, 64'h8000_0010);
    end
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("lu_cnt3", bubble_cnt, 64'd3);
    check("lu_issue", out_valid, 64'h1);
    check("lu_issue_pc", out_pc, 64'h8000_0010);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush while full, with fetch offering 0x200.
    cyc(1'b1, 64'h100, ins(64'h100), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h104, ins(64'h104), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h200, ins(64'h200), 1'b0, 1'b0, 1'b1);
    check("fl_ready", in_ready, 64'h0);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("fl_empty_valid", out_valid, 64'h0);
    check("fl_empty_ready", in_ready, 64'h1);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("fl_not_captured", out_valid, 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      automatic logic [63:0] rpc = {$urandom, $urandom};
      cyc($urandom_range(0, 3) != 0, rpc, $urandom, $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
    end
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges while full.
    cyc(1'b1, 64'h300, ins(64'h300), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h304, ins(64'h304), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    hazard_stall = 1'b0;
    out_ready = 1'b1;
    #1;
    check("ar_pre_valid", out_valid, 64'h1);
    check("ar_pre_cnt_nz", bubble_cnt != 16'h0, 64'h1);
    reset = 1'b1;
    #1;
    check("ar_valid_drop", out_valid, 64'h0);
    check("ar_ready_drop", in_ready, 64'h0);
    check("ar_cnt_clear", bubble_cnt, 64'h0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    cyc(1'b1, 64'h400, ins(64'h400), 1'b1, 1'b0, 1'b0);
    check("ar_post_ready", in_ready, 64'h1);
    check("ar_post_empty", out_valid, 64'h0);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("ar_post_pc", out_pc, 64'h400);
    check("ar_post_instr", out_instr, {32'h0, ins(64'h400)});
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Counter saturation.
    cyc(1'b1, 64'h500, ins(64'h500), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 65537; i++) cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("sat_max", bubble_cnt, 64'hFFFF);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("sat_hold", bubble_cnt, 64'hFFFF);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("sat_after", bubble_cnt, 64'hFFFF);
    check("sat_issue_pc", out_pc, 64'h500);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/decode_skid_ctrl.md
Name: decode_skid_ctrl

Overview:
- Flow controller for the decode stage of the five-stage RV64 pipeline.
- Accepts fetched instructions from fetch over a valid/ready handshake and buffers them in a 2-entry skid register (main + skid).
- Presents one instruction per cycle to the decode/execute boundary.
- Applies load-use stall (bubble insertion) and branch/exception flush, and counts bubble cycles for performance CSRs.

Parameters:
- PC_W, 64, width of program counter payload.
- INSTR_W, 32, width of raw instruction payload.
- CNT_W, 16, width of saturating bubble counter.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch offers an instruction.
- in_ready  output  1  controller can accept this cycle.
- in_pc  input  PC_W  PC of offered instruction.
- in_instr  input  INSTR_W  raw instruction bits.
- out_valid  output  1  instruction presented to decode/execute.
- out_ready  input  1  downstream accepts this cycle.
- out_pc  output  PC_W  PC of presented instruction.
- out_instr  output  INSTR_W  presented instruction bits.
- hazard_stall  input  1  load-use hazard: hold current instruction, emit bubble.
- flush  input  1  redirect: discard all buffered instructions.
- bubble_cnt  output  CNT_W  saturating count of stall-bubble cycles.

Behaviour:
- Reset (asynchronous, immediate):
  - state=EMPTY; main_valid=0, skid_valid=0.
  - main/skid payloads=0; bubble_cnt=0.
  - Outputs: out_valid=0, out_pc=0, out_instr=0, in_ready=0 while reset is high.
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_valid = main_valid & ~hazard_stall (combinational).
  - out_fire = out_valid & out_ready.
  - in_ready = (state != FULL) & ~flush & ~reset.
  - out_pc/out_instr are driven from the main register at all times, independent of hazard_stall.
- States:
  - EMPTY: no valid entries.
  - ONE: main valid only.
  - FULL: main and skid valid.
- Transitions (when flush=0):
  - EMPTY: in_fire -> ONE, main<=in. Otherwise stay.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in.
    - in_fire & ~out_fire -> FULL, skid<=in.
    - ~in_fire & out_fire -> EMPTY.
    - Otherwise stay.
  - FULL: in_ready=0. out_fire -> ONE, main<=skid. Otherwise stay.
- Ordering: strict program order. Zero-latency pass-through is not provided: an instruction accepted at edge N is presented from cycle N+1 at the earliest.
- Stability: while main_valid and no out_fire, out_pc/out_instr hold their values. out_valid may deassert/reassert with hazard_stall; payload does not change.
- hazard_stall:
  - Forces out_valid=0, so no out_fire.
  - Fetch may still fill the skid while in ONE.
  - Has no effect when main_valid=0.
- flush:
  - Highest priority. At the next edge: state=EMPTY, main_valid=skid_valid=0.
  - in_ready=0 during the flush cycle, so no instruction from that cycle is captured.
  - An out_fire in the flush cycle still counts as consumed downstream. Flush handling downstream is the consumer's responsibility.
- bubble_cnt:
  - +1 on each edge where main_valid & hazard_stall & ~flush.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Simultaneous flush and hazard_stall: flush wins; no count increment.
- Reset asserted mid-transfer: buffered instructions are lost. The first accepted instruction after deassertion enters main.

Test Plan:
- Reset then stream: in_valid=1 with PCs 0x80000000, +4, +8; out_ready=1 -> out_valid rises one cycle after first in_fire; PCs emerge in order one per cycle; state never FULL.
- Backpressure: hold out_ready=0 while offering 0x80000000, 0x80000004, 0x80000008 ->
  - first two accepted; in_ready=0 from the cycle after the second accept.
  - Release out_ready: outputs 0x80000000 then 0x80000004; third instruction accepted only after the first drain.
- Load-use stall: main holds 0x80000010, hazard_stall=1 for 3 cycles, out_ready=1 ->
  - out_valid=0 for 3 cycles; out_pc stays 0x80000010; bubble_cnt=3.
  - Instruction issues in the cycle after stall drops.
- Flush in FULL: state FULL with 0x100/0x104, assert flush for 1 cycle with in_valid=1 (PC 0x200) -> in_ready=0 that cycle; next cycle out_valid=0, state EMPTY; 0x200 not captured.
- Counter saturation: preload by holding hazard_stall with main_valid for 65537 cycles -> bubble_cnt=0xFFFF, stays 0xFFFF.
- Async reset mid-operation: assert reset between edges while FULL -> out_valid and in_ready drop immediately, bubble_cnt=0; after release, next instruction appears with no stale data.
